display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the four-digit seven-segment display. It divides the system clock into per-digit time slots and drives the active-low digit enables and the current digit nibble. It inserts dead-time blanking at each digit change, applies leading-zero suppression and PWM brightness, and double-buffers the 16-bit display value so updates take effect only at frame boundaries. It sits between the counter datapath (which supplies `count`) and the seven-segment decoder and anode pins.

---
 rtl/display_scan_ctrl.sv | 106 ++++++++++
 tb/tb_display_scan_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: per-digit time slots with dead-time
// blanking, leading-zero suppression, PWM brightness and a frame-synchronous display buffer.
module display_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] count,
  input  logic        load,
  output logic        load_ack,
  input  logic        lz_en,
  input  logic [2:0]  brightness,
  output logic [3:0]  digit_select,
  output logic [3:0]  cout,
  output logic        frame_start
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] LAST_CNT  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [DIV_W-1:0] SUB_LEN   = DIV_W'(SCAN_DIV / 8);

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_slot;
  logic [15:0]      r_shadow;
  logic             r_lz;
  logic [2:0]       r_bri;
  logic             r_load_ack;

  logic             w_boundary;
  logic [DIV_W-1:0] w_sub;
  logic [3:0]       w_nibble;
  logic [3:0]       w_sel_n;
  logic             w_lead_zero;
  logic             w_lit;

  assign w_boundary = (r_slot == 2'd3) && (r_div_cnt == LAST_CNT);

  // Shadow value and display settings only change on the last cycle of a frame,
  // so a frame is always drawn with one consistent value and setting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_slot     <= 2'd0;
      r_shadow   <= 16'h0000;
      r_lz       <= 1'b0;
      r_bri      <= 3'd7;
      r_load_ack <= 1'b0;
    end else begin
      if (r_div_cnt == LAST_CNT) begin
        r_div_cnt <= '0;
        r_slot    <= r_slot + 2'd1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      r_load_ack <= 1'b0;
      if (w_boundary) begin
        r_lz  <= lz_en;
        r_bri <= brightness;
        if (load) begin
          r_shadow   <= count;
          r_load_ack <= 1'b1;
        end
      end
    end
  end

  // Lead-zero test covers the current nibble and everything to its left.
  always_comb begin
    w_nibble    = r_shadow[3:0];
    w_sel_n     = 4'b1110;
    w_lead_zero = 1'b0;
    case (r_slot)
      2'd0: begin
        w_nibble    = r_shadow[15:12];
        w_sel_n     = 4'b0111;
        w_lead_zero = (r_shadow[15:12] == 4'h0);
      end
      2'd1: begin
        w_nibble    = r_shadow[11:8];
        w_sel_n     = 4'b1011;
        w_lead_zero = (r_shadow[15:8] == 8'h00);
      end
      2'd2: begin
        w_nibble    = r_shadow[7:4];
        w_sel_n     = 4'b1101;
        w_lead_zero = (r_shadow[15:4] == 12'h000);
      end
      default: begin
        w_nibble    = r_shadow[3:0];
        w_sel_n     = 4'b1110;
        w_lead_zero = 1'b0;
      end
    endcase
  end

  assign w_sub = r_div_cnt / SUB_LEN;
  assign w_lit = (r_div_cnt >= BLANK_END) && (w_sub <= DIV_W'(r_bri)) && !(r_lz && w_lead_zero);

  assign digit_select = w_lit ? w_sel_n : 4'b1111;
  assign cout         = w_nibble;
  assign frame_start  = (r_slot == 2'd0) && (r_div_cnt == '0);
  assign load_ack     = r_load_ack;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a 16-cycle slot and 2-cycle blanking:
// table of displayed frames plus hand-written handshake, brightness and reset sequences.
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] count;
  logic        load;
  logic        load_ack;
  logic        lz_en;
  logic [2:0]  brightness;
  logic [3:0]  digit_select;
  logic [3:0]  cout;
  logic        frame_start;

  int nCompared;
  int nMismatch;
  int framePos;

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [2:0]  bri;
    logic [3:0]  litMask;
    int          lastCyc;
  } vec_t;

  vec_t vecs [8];

  display_scan_ctrl #(.SCAN_DIV(16), .BLANK_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .count       (count),
    .load        (load),
    .load_ack    (load_ack),
    .lz_en       (lz_en),
    .brightness  (brightness),
    .digit_select(digit_select),
    .cout        (cout),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] value, input logic ld, input logic lz, input logic [2:0] bri);
    count      = value;
    load       = ld;
    lz_en      = lz;
    brightness = bri;
  endtask

  task automatic step();
    @(negedge clk);
    framePos = (framePos + 1) % 64;
  endtask

  task automatic gotoPos(input int p);
    for (int i = 0; i < 64 && framePos != p; i++) step();
  endtask

  task automatic countAcks(input int n, output int acks);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (load_ack) acks++;
    end
  endtask

  function automatic logic [3:0] nibbleOf(input logic [15:0] value, input int slot);
    logic [15:0] sh;
    sh = value >> (12 - 4 * slot);
    return sh[3:0];
  endfunction

  initial begin
    int waited;
    int acks;
    int slot;
    int d;
    logic lit;
    logic [3:0] expDs;
    logic [15:0] oldVal;

    nCompared = 0;
    nMismatch = 0;
    framePos  = 0;

    //               value     lz    bri   litMask  lastCyc
    vecs[0] = '{16'h1234, 1'b0, 3'd7, 4'b1111, 15};
    vecs[1] = '{16'h0050, 1'b1, 3'd7, 4'b1100, 15};
    vecs[2] = '{16'h0000, 1'b1, 3'd7, 4'b1000, 15};
    vecs[3] = '{16'h0305, 1'b1, 3'd7, 4'b1110, 15};
    vecs[4] = '{16'h1234, 1'b0, 3'd3, 4'b1111, 7};
    vecs[5] = '{16'h0000, 1'b0, 3'd0, 4'b1111, 1};
    vecs[6] = '{16'hABCD, 1'b1, 3'd7, 4'b1111, 15};
    vecs[7] = '{16'h0050, 1'b0, 3'd5, 4'b1111, 11};

    rst_n = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b0, 3'd7);
    repeat (3) @(negedge clk);
    checkOutput("rstDigitSel", 32'(digit_select), 32'hF);
    checkOutput("rstCout", 32'(cout), 32'h0);
    checkOutput("rstLoadAck", 32'(load_ack), 32'h0);
    checkOutput("rstFrameStart", 32'(frame_start), 32'h1);

    rst_n = 1'b1;
    framePos = 0;
    checkOutput("fsFirst", 32'(frame_start), 32'h1);
    for (int c = 1; c <= 64; c++) begin
      step();
      checkOutput($sformatf("fsPeriod_c%0d", c), 32'(frame_start), 32'(c == 64));
    end

    $display("[TB] frame table");
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].value, 1'b1, vecs[v].lz, vecs[v].bri);
      waited = 0;
      for (int i = 0; i < 70 && !load_ack; i++) begin
        step();
        waited++;
      end
      if (!load_ack) begin
        checkOutput($sformatf("ackTimeout%0d", v), 32'h0, 32'h1);
        continue;
      end
      load = 1'b0;
      checkOutput($sformatf("ackPhase%0d", v), 32'(framePos), 32'h0);
      checkOutput($sformatf("ackWithFs%0d", v), 32'(frame_start), 32'h1);
      for (int c = 0; c < 64; c++) begin
        if (c != 0) step();
        slot  = c / 16;
        d     = c % 16;
        lit   = vecs[v].litMask[slot] && (d >= 2) && (d <= vecs[v].lastCyc);
        expDs = lit ? ~(4'b1000 >> slot) : 4'b1111;
        checkOutput($sformatf("scan%0d_c%0d", v, c), {24'h0, digit_select, cout},
                    {24'h0, expDs, nibbleOf(vecs[v].value, slot)});
      end
    end

    $display("[TB] handshake");
    oldVal = vecs[7].value;
    applyStimulus(16'h0050, 1'b0, 1'b0, 3'd7);
    gotoPos(21);
    applyStimulus(16'hABCD, 1'b1, 1'b0, 3'd7);
    waited = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      waited++;
      if (load_ack) break;
      checkOutput($sformatf("shadowHeld_p%0d", framePos), 32'(cout), 32'(nibbleOf(oldVal, framePos / 16)));
    end
    load = 1'b0;
    checkOutput("hsLatency", 32'(waited), 32'd43);
    checkOutput("hsFrameStart", 32'(frame_start), 32'h1);
    checkOutput("hsNewNibble", 32'(cout), 32'hA);
    step();
    checkOutput("ackPulse", 32'(load_ack), 32'h0);

    applyStimulus(16'h9999, 1'b0, 1'b0, 3'd7);
    countAcks(64, acks);
    checkOutput("noLoadNoAck", 32'(acks), 32'h0);
    checkOutput("noLoadKeepsA", 32'(cout), 32'hA);

    gotoPos(30);
    applyStimulus(16'h1111, 1'b1, 1'b0, 3'd7);
    gotoPos(50);
    load = 1'b0;
    countAcks(19, acks);
    checkOutput("withdrawNoAck", 32'(acks), 32'h0);
    checkOutput("withdrawKeepsA", 32'(cout), 32'hA);

    gotoPos(63);
    applyStimulus(16'h7E57, 1'b1, 1'b0, 3'd7);
    step();
    load = 1'b0;
    checkOutput("edgeLoadAck", 32'(load_ack), 32'h1);
    checkOutput("edgeLoadNibble", 32'(cout), 32'h7);

    $display("[TB] brightness mid-frame");
    gotoPos(20);
    brightness = 3'd3;
    gotoPos(26);
    checkOutput("briOldSlot1", 32'(digit_select), 32'hB);
    gotoPos(42);
    checkOutput("briOldSlot2", 32'(digit_select), 32'hD);
    gotoPos(63);
    step();
    gotoPos(5);
    checkOutput("briNewLit", {24'h0, digit_select, cout}, {24'h0, 4'h7, 4'h7});
    gotoPos(10);
    checkOutput("briNewDark", 32'(digit_select), 32'hF);

    $display("[TB] reset mid-operation");
    brightness = 3'd7;
    gotoPos(36);
    applyStimulus(16'h5555, 1'b1, 1'b0, 3'd7);
    gotoPos(40);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstDigitSel", 32'(digit_select), 32'hF);
    checkOutput("midRstCout", 32'(cout), 32'h0);
    checkOutput("midRstAck", 32'(load_ack), 32'h0);
    repeat (2) @(negedge clk);
    load = 1'b0;
    rst_n = 1'b1;
    framePos = 0;
    checkOutput("restartFs", 32'(frame_start), 32'h1);
    gotoPos(2);
    checkOutput("restartSlot0", {24'h0, digit_select, cout}, {24'h0, 4'h7, 4'h0});
    gotoPos(18);
    checkOutput("restartSlot1", 32'(digit_select), 32'hB);
    countAcks(64, acks);
    checkOutput("restartNoAck", 32'(acks), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
